bus_slave_router: RTL and testbench

//  Slave-side routing controller for the system bus. Sits after the master arbiter.

---
 rtl/bus_slave_router.sv | 176 +++++++++++++++++
 tb/tb_bus_slave_router.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_router.sv
// Slave-side bus router: shifts in a serial slave id, enables that slave, waits for
// ready (bounded), holds the route until done, then requests bus release.
module bus_slave_router #(
  parameter int N_SLAVES = 3,
  parameter int SID_W    = 2,
  parameter int TIMEOUT  = 16,
  parameter int TO_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bus_busy,
  input  logic                sel_valid,
  input  logic                sel_bit,
  input  logic [N_SLAVES-1:0] slave_ready,
  input  logic [N_SLAVES-1:0] slave_done,
  output logic [N_SLAVES-1:0] slave_en,
  output logic [SID_W-1:0]    slave_grant,
  output logic                route_ack,
  output logic                route_err,
  // "release" is a reserved word, so the release request is named release_req
  output logic                release_req
);

  localparam int BC_W = $clog2(SID_W + 1);
  localparam logic [SID_W:0] ID_LIMIT = (SID_W + 1)'(N_SLAVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_RDY,
    S_ACTIVE,
    S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [SID_W-1:0]    shift_q, shift_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [N_SLAVES-1:0] slave_en_q, slave_en_d;
  logic [SID_W-1:0]    slave_grant_q, slave_grant_d;
  logic                route_ack_q, route_ack_d;
  logic                route_err_q, route_err_d;
  logic                release_q, release_d;

  logic [SID_W-1:0]    sid_next;
  logic                ready_hit;
  logic                done_hit;

  // slave_en_q is one-hot on the routed slave, so masking ignores all other slaves
  assign sid_next  = (shift_q << 1) | SID_W'(sel_bit);
  assign ready_hit = |(slave_ready & slave_en_q);
  assign done_hit  = |(slave_done & slave_en_q);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    slave_en_d    = slave_en_q;
    slave_grant_d = slave_grant_q;
    route_ack_d   = 1'b0;
    route_err_d   = 1'b0;
    release_d     = release_q;

    case (state_q)
      S_IDLE: begin
        slave_en_d    = '0;
        slave_grant_d = '0;
        release_d     = 1'b0;
        if (bus_busy) begin
          state_d   = S_ADDR;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end

      S_ADDR: begin
        if (!bus_busy) begin
          state_d = S_IDLE;
        end else if (sel_valid) begin
          shift_d   = sid_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BC_W'(SID_W - 1)) begin
            if ({1'b0, sid_next} < ID_LIMIT) begin
              state_d       = S_WAIT_RDY;
              to_cnt_d      = '0;
              slave_grant_d = sid_next;
              slave_en_d    = N_SLAVES'(1) << sid_next;
            end else begin
              state_d     = S_RELEASE;
              route_err_d = 1'b1;
              release_d   = 1'b1;
            end
          end
        end
      end

      S_WAIT_RDY: begin
        if (!bus_busy) begin
          state_d       = S_IDLE;
          slave_en_d    = '0;
          slave_grant_d = '0;
        end else if (ready_hit) begin
          state_d     = S_ACTIVE;
          route_ack_d = 1'b1;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d       = S_RELEASE;
          route_err_d   = 1'b1;
          release_d     = 1'b1;
          slave_en_d    = '0;
          slave_grant_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_ACTIVE: begin
        if (!bus_busy) begin
          state_d       = S_IDLE;
          slave_en_d    = '0;
          slave_grant_d = '0;
        end else if (done_hit) begin
          state_d       = S_RELEASE;
          release_d     = 1'b1;
          slave_en_d    = '0;
          slave_grant_d = '0;
        end
      end

      S_RELEASE: begin
        if (!bus_busy) begin
          state_d   = S_IDLE;
          release_d = 1'b0;
        end
      end

      default: begin
        state_d       = S_IDLE;
        slave_en_d    = '0;
        slave_grant_d = '0;
        release_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      slave_en_q    <= '0;
      slave_grant_q <= '0;
      route_ack_q   <= 1'b0;
      route_err_q   <= 1'b0;
      release_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      slave_en_q    <= slave_en_d;
      slave_grant_q <= slave_grant_d;
      route_ack_q   <= route_ack_d;
      route_err_q   <= route_err_d;
      release_q     <= release_d;
    end
  end

  assign slave_en    = slave_en_q;
  assign slave_grant = slave_grant_q;
  assign route_ack   = route_ack_q;
  assign route_err   = route_err_q;
  assign release_req = release_q;

endmodule

// File: tb/tb_bus_slave_router.sv
// Directed bench for bus_slave_router: outputs packed as {slave_en, slave_grant, ack, err, release}.
module tb_bus_slave_router;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_busy;
  logic       sel_valid;
  logic       sel_bit;
  logic [2:0] slave_ready;
  logic [2:0] slave_done;
  logic [2:0] slave_en;
  logic [1:0] slave_grant;
  logic       route_ack;
  logic       route_err;
  logic       release_req;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  bus_slave_router #(
    .N_SLAVES(3),
    .SID_W   (2),
    .TIMEOUT (16),
    .TO_W    (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_busy   (bus_busy),
    .sel_valid  (sel_valid),
    .sel_bit    (sel_bit),
    .slave_ready(slave_ready),
    .slave_done (slave_done),
    .slave_en   (slave_en),
    .slave_grant(slave_grant),
    .route_ack  (route_ack),
    .route_err  (route_err),
    .release_req(release_req)
  );

  always #5 clk = ~clk;

  assign outs = {slave_en, slave_grant, route_ack, route_err, release_req};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sel_valid = 1'b1;
    sel_bit   = b;
    step();
    sel_valid = 1'b0;
    sel_bit   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus_busy = 1'b1; sel_valid = 1'b1; sel_bit = 1'b1;
    slave_ready = 3'b111; slave_done = 3'b111;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== 8'b000_00_000) begin errors++; $display("FAIL reset_outs cyc%0d got=%b exp=%b", i, outs, 8'b000_00_000); end
    end
    reset = 1'b1; bus_busy = 1'b0; sel_valid = 1'b0; sel_bit = 1'b0;
    slave_ready = 3'b000; slave_done = 3'b000;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL reset_idle got=%b exp=%b", outs, 8'b000_00_000); end
  endtask

  task automatic test_route();
    bus_busy = 1'b1;
    step();
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (outs !== 8'b100_10_000) begin errors++; $display("FAIL route_grant got=%b exp=%b", outs, 8'b100_10_000); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (outs !== 8'b100_10_000) begin errors++; $display("FAIL route_wait cyc%0d got=%b exp=%b", i, outs, 8'b100_10_000); end
    end
    slave_ready = 3'b100;
    step();
    slave_ready = 3'b000;
    checks++;
    if (outs !== 8'b100_10_100) begin errors++; $display("FAIL route_ack got=%b exp=%b", outs, 8'b100_10_100); end
    step();
    checks++;
    if (outs !== 8'b100_10_000) begin errors++; $display("FAIL route_ack_single got=%b exp=%b", outs, 8'b100_10_000); end
    slave_done = 3'b100;
    step();
    slave_done = 3'b000;
    checks++;
    if (outs !== 8'b000_00_001) begin errors++; $display("FAIL route_release got=%b exp=%b", outs, 8'b000_00_001); end
    step();
    checks++;
    if (outs !== 8'b000_00_001) begin errors++; $display("FAIL route_release_hold got=%b exp=%b", outs, 8'b000_00_001); end
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL route_drop got=%b exp=%b", outs, 8'b000_00_000); end
  endtask

  task automatic test_illegal_id();
    bus_busy = 1'b1;
    step();
    send_bit(1'b1);
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL illegal_first_bit got=%b exp=%b", outs, 8'b000_00_000); end
    send_bit(1'b1);
    checks++;
    if (outs !== 8'b000_00_011) begin errors++; $display("FAIL illegal_err got=%b exp=%b", outs, 8'b000_00_011); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== 8'b000_00_001) begin errors++; $display("FAIL illegal_hold cyc%0d got=%b exp=%b", i, outs, 8'b000_00_001); end
    end
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL illegal_drop got=%b exp=%b", outs, 8'b000_00_000); end
  endtask

  task automatic test_timeout();
    bus_busy = 1'b1;
    step();
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (outs !== 8'b010_01_000) begin errors++; $display("FAIL timeout_grant got=%b exp=%b", outs, 8'b010_01_000); end
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (i < 16 && outs !== 8'b010_01_000) begin errors++; $display("FAIL timeout_wait cyc%0d got=%b exp=%b", i, outs, 8'b010_01_000); end
      else if (i == 16 && outs !== 8'b000_00_011) begin errors++; $display("FAIL timeout_err got=%b exp=%b", outs, 8'b000_00_011); end
    end
    step();
    checks++;
    if (outs !== 8'b000_00_001) begin errors++; $display("FAIL timeout_err_single got=%b exp=%b", outs, 8'b000_00_001); end
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL timeout_drop got=%b exp=%b", outs, 8'b000_00_000); end
  endtask

  task automatic test_edge_ready();
    bus_busy = 1'b1;
    step();
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if (outs !== 8'b001_00_000) begin errors++; $display("FAIL edge_grant got=%b exp=%b", outs, 8'b001_00_000); end
    slave_ready = 3'b010; slave_done = 3'b010;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++;
      if (outs !== 8'b001_00_000) begin errors++; $display("FAIL edge_wait cyc%0d got=%b exp=%b", i, outs, 8'b001_00_000); end
    end
    slave_ready = 3'b011;
    step();
    slave_ready = 3'b010;
    checks++;
    if (outs !== 8'b001_00_100) begin errors++; $display("FAIL edge_ack got=%b exp=%b", outs, 8'b001_00_100); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== 8'b001_00_000) begin errors++; $display("FAIL edge_foreign_done cyc%0d got=%b exp=%b", i, outs, 8'b001_00_000); end
    end
    slave_done = 3'b011;
    step();
    slave_ready = 3'b000; slave_done = 3'b000;
    checks++;
    if (outs !== 8'b000_00_001) begin errors++; $display("FAIL edge_release got=%b exp=%b", outs, 8'b000_00_001); end
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL edge_drop got=%b exp=%b", outs, 8'b000_00_000); end
  endtask

  task automatic test_abort_stall();
    bus_busy = 1'b1;
    step();
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (outs !== 8'b000_00_000) begin errors++; $display("FAIL stall_gap cyc%0d got=%b exp=%b", i, outs, 8'b000_00_000); end
    end
    send_bit(1'b0);
    checks++;
    if (outs !== 8'b100_10_000) begin errors++; $display("FAIL stall_grant got=%b exp=%b", outs, 8'b100_10_000); end
    slave_ready = 3'b100;
    step();
    slave_ready = 3'b000;
    checks++;
    if (outs !== 8'b100_10_100) begin errors++; $display("FAIL stall_ack got=%b exp=%b", outs, 8'b100_10_100); end
    step();
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL abort_active got=%b exp=%b", outs, 8'b000_00_000); end
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL abort_no_release got=%b exp=%b", outs, 8'b000_00_000); end

    // abort while waiting for ready
    bus_busy = 1'b1;
    step();
    send_bit(1'b0);
    send_bit(1'b1);
    step();
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL abort_wait got=%b exp=%b", outs, 8'b000_00_000); end

    // abort during id shift: a later full id must start from scratch
    bus_busy = 1'b1;
    step();
    send_bit(1'b1);
    bus_busy = 1'b0;
    step();
    bus_busy = 1'b1;
    step();
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (outs !== 8'b010_01_000) begin errors++; $display("FAIL abort_addr_restart got=%b exp=%b", outs, 8'b010_01_000); end

    slave_ready = 3'b010;
    step();
    slave_ready = 3'b000;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL reset_mid_active got=%b exp=%b", outs, 8'b000_00_000); end
    reset = 1'b1;
    bus_busy = 1'b0;
    step();
    checks++;
    if (outs !== 8'b000_00_000) begin errors++; $display("FAIL reset_after got=%b exp=%b", outs, 8'b000_00_000); end
  endtask

  initial begin
    reset = 1'b0; bus_busy = 1'b0; sel_valid = 1'b0; sel_bit = 1'b0;
    slave_ready = 3'b000; slave_done = 3'b000;
    test_reset();
    test_route();
    step();
    test_illegal_id();
    step();
    test_timeout();
    step();
    test_edge_ready();
    step();
    test_abort_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
